router_ingress_queue: RTL and testbench

//   Ingress buffer directly upstream of the 4-port address demux router.
//   - Accepts {data, destination addr} words over a valid/ready handshake and queues them in order.
//   - Replays each queued word onto the router's din/din_en/addr bus as a single-cycle, registered strobe.
//   - Decouples bursty producers from the router, and lets downstream logic pause issue.

---
 rtl/router_pkg.sv | 7 +
 rtl/router_sync_fifo.sv | 56 +++++
 rtl/router_ingress_queue.sv | 81 ++++++++
 tb/tb_router_ingress_queue.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: port count, address width and the port address type.
package router_pkg;
  localparam int NUM_PORTS = 4;
  localparam int ADDR_W    = 2;

  typedef logic [ADDR_W-1:0] port_addr_t;
endpackage

// File: rtl/router_sync_fifo.sv
// Generic synchronous FIFO: storage, wrapping pointers, exact occupancy count,
// full/empty flags. The read port shows the head entry combinationally.
module router_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count follows push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/router_ingress_queue.sv
// Ingress queue ahead of the 4-port address demux router. Buffers {data, addr}
// words and replays each as a registered single-cycle din_en strobe.
// Optional feature macro: ROUTER_PORT_MASK_EN adds port_en[3:0]; a head word
// whose destination port is disabled stalls issue until that port is enabled.
module router_ingress_queue
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef ROUTER_PORT_MASK_EN
  input  logic [NUM_PORTS-1:0]    port_en,
`endif
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  port_addr_t              in_addr,
  output logic                    in_ready,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   din,
  output logic                    din_en,
  output port_addr_t              addr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int EW = DATA_WIDTH + ADDR_W;

  logic [EW-1:0]         head;
  logic [DATA_WIDTH-1:0] head_data;
  port_addr_t            head_addr;
  logic                  head_allowed;
  logic                  push;
  logic                  pop;

  assign head_data = head[EW-1:ADDR_W];
  assign head_addr = head[ADDR_W-1:0];

`ifdef ROUTER_PORT_MASK_EN
  assign head_allowed = port_en[head_addr];
`else
  assign head_allowed = 1'b1;
`endif

  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && out_ready && head_allowed && !reset;

  router_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data ({in_data, in_addr}),
    .pop     (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Issue register: load the head word on a pop, otherwise drive all-zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      din    <= '0;
      addr   <= '0;
      din_en <= 1'b0;
    end else if (pop) begin
      din    <= head_data;
      addr   <= head_addr;
      din_en <= 1'b1;
    end else begin
      din    <= '0;
      addr   <= '0;
      din_en <= 1'b0;
    end
  end
endmodule

// File: tb/tb_router_ingress_queue.sv
// Self-checking bench for router_ingress_queue: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_router_ingress_queue;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    a;
  } word_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    port_en = 4'hF;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_addr = '0;
  logic          in_ready;
  logic          out_ready = 1'b0;
  logic [DW-1:0] din;
  logic          din_en;
  logic [1:0]    addr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  word_t         q[$];
  logic [DW-1:0] exp_din;
  logic          exp_en;
  logic [1:0]    exp_addr;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  router_ingress_queue #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef ROUTER_PORT_MASK_EN
    .port_en   (port_en),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .din       (din),
    .din_en    (din_en),
    .addr      (addr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after negedge, check in_ready, update model at
  // posedge (pop uses pre-edge contents, then push), check registered outputs.
  task automatic cycle(input logic rst, input logic v, input logic [DW-1:0] d,
                       input logic [1:0] a, input logic ordy);
    int    sz;
    logic  allowed;
    word_t w;
    @(negedge clk);
    reset = rst; in_valid = v; in_data = d; in_addr = a; out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(!rst && q.size() < DEPTH));
    @(posedge clk);
    exp_din = '0; exp_en = 1'b0; exp_addr = '0;
    if (rst) begin
      q.delete();
    end else begin
      sz = q.size();
      allowed = 1'b1;
`ifdef ROUTER_PORT_MASK_EN
      if (sz > 0) allowed = port_en[q[0].a];
`endif
      if (sz > 0 && ordy && allowed) begin
        w = q.pop_front();
        exp_din = w.d; exp_addr = w.a; exp_en = 1'b1;
      end
      if (v && sz < DEPTH) q.push_back('{d: d, a: a});
    end
    #1;
    chk("din_en", 64'(din_en), 64'(exp_en));
    chk("din",    64'(din),    64'(exp_din));
    chk("addr",   64'(addr),   64'(exp_addr));
    chk("count",  64'(count),  64'(q.size()));
    chk("full",   64'(full),   64'(q.size() == DEPTH));
    chk("empty",  64'(empty),  64'(q.size() == 0));
  endtask

  initial begin
    // 1: reset then idle
    cycle(1'b1, 1'b0, '0, 2'd0, 1'b0);
    cycle(1'b1, 1'b0, '0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 2'd0, 1'b1);

    // 2: single push, single strobe on the next edge
    cycle(1'b0, 1'b1, 32'hA5A5_A5A5, 2'd2, 1'b1);
    cycle(1'b0, 1'b0, '0, 2'd0, 1'b1);
    chk("t2_din", 64'(din), 64'hA5A5_A5A5);
    chk("t2_addr", 64'(addr), 64'd2);
    cycle(1'b0, 1'b0, '0, 2'd0, 1'b1);
    chk("t2_strobe_end", 64'(din_en), 64'd0);

    // 3: fill while paused, then drain back-to-back in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 32'h1000 + 32'(i), 2'(i), 1'b0);
    chk("t3_full", 64'(full), 64'd1);
    cycle(1'b0, 1'b1, 32'hDEAD, 2'd1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, '0, 2'd0, 1'b1);

    // 4: steady push+pop with 3 resident words, pointers wrap several times
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, $urandom, 2'($urandom_range(0, 3)), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, $urandom, 2'($urandom_range(0, 3)), 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 2'd0, 1'b1);

    // 5: reset with 5 words stored; nothing stale may issue afterwards
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h5000 + 32'(i), 2'(i), 1'b0);
    cycle(1'b1, 1'b1, 32'hBAD0, 2'd3, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 2'd0, 1'b1);

`ifdef ROUTER_PORT_MASK_EN
    // 6: head-of-line stall on a disabled port
    port_en = 4'b1011;
    cycle(1'b0, 1'b1, 32'h6002, 2'd2, 1'b1);
    cycle(1'b0, 1'b1, 32'h6000, 2'd0, 1'b1);
    cycle(1'b0, 1'b1, 32'h6001, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 2'd0, 1'b1);
    port_en = 4'b1111;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 2'd0, 1'b1);
`endif

    // Randomized traffic with occasional pauses, resets and port masking
    for (int i = 0; i < 400; i++) begin
`ifdef ROUTER_PORT_MASK_EN
      if ($urandom_range(0, 7) == 0) port_en = 4'($urandom);
`endif
      cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), $urandom,
            2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
    end
    port_en = 4'hF;
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b0, '0, 2'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
